// File: rtl/svm_cfg_pkg.sv
// svm_cfg_regfile shared definitions: register map,
// reset values, lock states and ERR bit positions.
package svm_cfg_pkg;

  localparam logic [31:0] CFG_ADDR_OP_MODE     = 32'd0;
  localparam logic [31:0] CFG_ADDR_DATA_TYPE   = 32'd1;
  localparam logic [31:0] CFG_ADDR_AUTO_SPLIT  = 32'd2;
  localparam logic [31:0] CFG_ADDR_TRAIN_BASE  = 32'd3;
  localparam logic [31:0] CFG_ADDR_TEST_BASE   = 32'd4;
  localparam logic [31:0] CFG_ADDR_TRAIN_ALGO  = 32'd5;
  localparam logic [31:0] CFG_ADDR_NUM_DIM     = 32'd6;
  localparam logic [31:0] CFG_ADDR_NUM_PTS     = 32'd7;
  localparam logic [31:0] CFG_ADDR_DS_ORG      = 32'd8;
  localparam logic [31:0] CFG_ADDR_CTRL        = 32'd9;
  localparam logic [31:0] CFG_ADDR_STATUS      = 32'd10;
  localparam logic [31:0] CFG_ADDR_ERR         = 32'd11;
  localparam logic [31:0] CFG_ADDR_INFER_BASE  = 32'd12;
  localparam logic [31:0] CFG_ADDR_INFER_BLK   = 32'd13;
  localparam logic [31:0] CFG_ADDR_SCATTER     = 32'd14;
  localparam logic [31:0] CFG_ADDR_RSVD        = 32'd15;
  localparam logic [31:0] CFG_ADDR_DIM_BASE    = 32'd16;

  localparam logic [31:0] RST_OP_MODE     = 32'd1;
  localparam logic [31:0] RST_DATA_TYPE   = 32'd2;
  localparam logic [31:0] RST_AUTO_SPLIT  = 32'h3e4c_cccd;
  localparam logic [31:0] RST_TRAIN_ALGO  = 32'd1;
  localparam logic [31:0] RST_NUM_DIM     = 32'd2;
  localparam logic [31:0] RST_NUM_PTS     = 32'd1024;
  localparam logic [31:0] RST_DS_ORG      = 32'd2;
  localparam logic [31:0] RST_INFER_BASE  = 32'h200;
  localparam logic [31:0] RST_INFER_BLK   = 32'd1;

  typedef enum logic {
    CFG_OPEN,
    CFG_LOCKED
  } cfg_lock_e;

  localparam int ERR_LOCKED  = 0;
  localparam int ERR_ADDR    = 1;
  localparam int ERR_NUM_DIM = 2;

endpackage

// File: rtl/svm_cfg_regfile_if.sv
// Host config bus: valid/ready request channel
// plus write ack and held read response.
interface svm_cfg_regfile_if #(
  parameter int ADDR_W = 16
);
  logic              cfg_req_vld;
  logic              cfg_req_rdy;
  logic              cfg_data_rb_w;
  logic [ADDR_W-1:0] cfg_addr;
  logic [31:0]       cfg_data;
  logic              cfg_wr_ack;
  logic              cfg_wr_err;
  logic              cfg_rd_vld;
  logic              cfg_rd_rdy;
  logic [31:0]       cfg_rd_data;

  modport master (
    output cfg_req_vld, cfg_data_rb_w,
    output cfg_addr, cfg_data, cfg_rd_rdy,
    input  cfg_req_rdy, cfg_wr_ack,
    input  cfg_wr_err, cfg_rd_vld, cfg_rd_data
  );

  modport slave (
    input  cfg_req_vld, cfg_data_rb_w,
    input  cfg_addr, cfg_data, cfg_rd_rdy,
    output cfg_req_rdy, cfg_wr_ack,
    output cfg_wr_err, cfg_rd_vld, cfg_rd_data
  );
endinterface

// File: rtl/svm_cfg_rd_resp.sv
// Read response holding register; blocks new
// requests while a response is outstanding.
module svm_cfg_rd_resp
  import svm_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_acc,
  input  logic [31:0] rd_data_in,
  input  logic        rd_rdy,
  output logic        rd_vld,
  output logic [31:0] rd_data,
  output logic        req_rdy
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else if (rd_acc) begin
      rd_vld  <= 1'b1;
      rd_data <= rd_data_in;
    end else if (rd_vld && rd_rdy) begin
      rd_vld  <= 1'b0;
    end
  end

  assign req_rdy = ~rd_vld;

endmodule

// File: rtl/svm_cfg_regfile.sv
// SVM config/status register file with commit lock.
// Define SVM_CFG_ERR_CAPTURE_EN for ERR[31:16] address capture.
module svm_cfg_regfile
  import svm_cfg_pkg::*;
#(
  parameter int MAX_DIM = 4,
  parameter int ADDR_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  svm_cfg_regfile_if.slave     bus,
  input  logic                 batch_comp_done,
  input  logic                 core_busy,
  output logic [1:0]           op_mode,
  output logic [2:0]           data_type,
  output logic [31:0]          auto_split,
  output logic [31:0]          train_data_base,
  output logic [31:0]          test_data_base,
  output logic [31:0]          train_algo,
  output logic [31:0]          num_dim,
  output logic [31:0]          num_data_points,
  output logic [31:0]          mode_dataset_org,
  output logic [31:0]          infer_res_base_ptr,
  output logic [31:0]          infer_res_blk_size,
  output logic [31:0]          scatter_base_ptr,
  output logic [MAX_DIM*32-1:0] dim_base_ptr,
  output logic                 cfg_done,
  output logic                 irq
);

  localparam logic [31:0] DIM_END =
    CFG_ADDR_DIM_BASE + 32'(MAX_DIM);

  cfg_lock_e   lock_q, lock_n;
  logic [31:0] a32, rdata, nd_val;
  logic [31:0] dim_q [MAX_DIM];
  logic        acc, wr, rd, wr_ok;
  logic        in_dim, bad_addr, lockable;
  logic        is_ctrl, unlock_busy, rej_lock;
  logic        nd_clamp, status_q, status_n;
  logic [2:0]  err_q, err_n, err_set, w1c;
  logic [15:0] err_hi;
  logic        ack_q, wr_err_q;

  assign a32 = 32'(bus.cfg_addr);
  assign acc = bus.cfg_req_vld & bus.cfg_req_rdy;
  assign wr  = acc & bus.cfg_data_rb_w;
  assign rd  = acc & ~bus.cfg_data_rb_w;

  assign in_dim   = (a32 >= CFG_ADDR_DIM_BASE) &&
                    (a32 < DIM_END);
  assign bad_addr = (a32 >= CFG_ADDR_RSVD) && !in_dim;
  assign lockable = (a32 <= CFG_ADDR_DS_ORG) || in_dim ||
                    ((a32 >= CFG_ADDR_INFER_BASE) &&
                     (a32 <= CFG_ADDR_SCATTER));
  assign is_ctrl  = (a32 == CFG_ADDR_CTRL);

  // Unlocking while the core runs a batch is refused.
  assign unlock_busy = is_ctrl & ~bus.cfg_data[0] &
                       (lock_q == CFG_LOCKED) & core_busy;
  assign rej_lock = ((lock_q == CFG_LOCKED) & lockable) |
                    unlock_busy;
  assign wr_ok = wr & ~bad_addr & ~rej_lock;

  always_comb begin
    nd_clamp = 1'b0;
    nd_val   = bus.cfg_data;
    if (bus.cfg_data == 32'd0) begin
      nd_clamp = 1'b1;
      nd_val   = 32'd1;
    end else if (bus.cfg_data > 32'(MAX_DIM)) begin
      nd_clamp = 1'b1;
      nd_val   = 32'(MAX_DIM);
    end
  end

  always_comb begin
    err_set = '0;
    err_set[ERR_LOCKED]  = wr & rej_lock;
    err_set[ERR_ADDR]    = acc & bad_addr;
    err_set[ERR_NUM_DIM] = wr_ok & nd_clamp &
                           (a32 == CFG_ADDR_NUM_DIM);
    w1c = '0;
    if (wr_ok && a32 == CFG_ADDR_ERR)
      w1c = bus.cfg_data[2:0];
  end

  // Hardware set beats a same-cycle W1C.
  assign err_n    = (err_q & ~w1c) | err_set;
  assign status_n = (status_q &
                     ~(wr_ok & bus.cfg_data[0] &
                       (a32 == CFG_ADDR_STATUS))) |
                    batch_comp_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_q <= CFG_OPEN;
    else     lock_q <= lock_n;
  end

  always_comb begin
    lock_n = lock_q;
    unique case (lock_q)
      CFG_OPEN:
        if (wr_ok && is_ctrl && bus.cfg_data[0])
          lock_n = CFG_LOCKED;
      CFG_LOCKED:
        if (wr_ok && is_ctrl && !bus.cfg_data[0])
          lock_n = CFG_OPEN;
      default: lock_n = CFG_OPEN;
    endcase
  end

`ifdef SVM_CFG_ERR_CAPTURE_EN
  logic [15:0] cap_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cap_q <= '0;
    else if ((err_set != '0) && (err_q == '0))
      cap_q <= a32[15:0];
    else if (err_n == '0)
      cap_q <= '0;
  end
  assign err_hi = cap_q;
`else
  assign err_hi = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_mode            <= RST_OP_MODE[1:0];
      data_type          <= RST_DATA_TYPE[2:0];
      auto_split         <= RST_AUTO_SPLIT;
      train_data_base    <= '0;
      test_data_base     <= '0;
      train_algo         <= RST_TRAIN_ALGO;
      num_dim            <= RST_NUM_DIM;
      num_data_points    <= RST_NUM_PTS;
      mode_dataset_org   <= RST_DS_ORG;
      infer_res_base_ptr <= RST_INFER_BASE;
      infer_res_blk_size <= RST_INFER_BLK;
      scatter_base_ptr   <= '0;
      for (int d = 0; d < MAX_DIM; d++)
        dim_q[d] <= '0;
      status_q <= 1'b0;
      err_q    <= '0;
      ack_q    <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      status_q <= status_n;
      err_q    <= err_n;
      ack_q    <= wr;
      wr_err_q <= wr & ~wr_ok;
      if (wr_ok) begin
        case (a32)
          CFG_ADDR_OP_MODE:
            op_mode <= bus.cfg_data[1:0];
          CFG_ADDR_DATA_TYPE:
            data_type <= bus.cfg_data[2:0];
          CFG_ADDR_AUTO_SPLIT:
            auto_split <= bus.cfg_data;
          CFG_ADDR_TRAIN_BASE:
            train_data_base <= bus.cfg_data;
          CFG_ADDR_TEST_BASE:
            test_data_base <= bus.cfg_data;
          CFG_ADDR_TRAIN_ALGO:
            train_algo <= bus.cfg_data;
          CFG_ADDR_NUM_DIM:
            num_dim <= nd_val;
          CFG_ADDR_NUM_PTS:
            num_data_points <= bus.cfg_data;
          CFG_ADDR_DS_ORG:
            mode_dataset_org <= bus.cfg_data;
          CFG_ADDR_INFER_BASE:
            infer_res_base_ptr <= bus.cfg_data;
          CFG_ADDR_INFER_BLK:
            infer_res_blk_size <= bus.cfg_data;
          CFG_ADDR_SCATTER:
            scatter_base_ptr <= bus.cfg_data;
          default:
            for (int d = 0; d < MAX_DIM; d++)
              if (a32 == CFG_ADDR_DIM_BASE + 32'(d))
                dim_q[d] <= bus.cfg_data;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (a32)
      CFG_ADDR_OP_MODE:    rdata = {30'd0, op_mode};
      CFG_ADDR_DATA_TYPE:  rdata = {29'd0, data_type};
      CFG_ADDR_AUTO_SPLIT: rdata = auto_split;
      CFG_ADDR_TRAIN_BASE: rdata = train_data_base;
      CFG_ADDR_TEST_BASE:  rdata = test_data_base;
      CFG_ADDR_TRAIN_ALGO: rdata = train_algo;
      CFG_ADDR_NUM_DIM:    rdata = num_dim;
      CFG_ADDR_NUM_PTS:    rdata = num_data_points;
      CFG_ADDR_DS_ORG:     rdata = mode_dataset_org;
      CFG_ADDR_CTRL:       rdata = {31'd0, cfg_done};
      CFG_ADDR_STATUS:     rdata = {31'd0, status_q};
      CFG_ADDR_ERR:
        rdata = {err_hi, 13'd0, err_q};
      CFG_ADDR_INFER_BASE: rdata = infer_res_base_ptr;
      CFG_ADDR_INFER_BLK:  rdata = infer_res_blk_size;
      CFG_ADDR_SCATTER:    rdata = scatter_base_ptr;
      default:
        for (int d = 0; d < MAX_DIM; d++)
          if (a32 == CFG_ADDR_DIM_BASE + 32'(d))
            rdata = dim_q[d];
    endcase
  end

  svm_cfg_rd_resp u_rd_resp (
    .clk        (clk),
    .rst        (rst),
    .rd_acc     (rd),
    .rd_data_in (rdata),
    .rd_rdy     (bus.cfg_rd_rdy),
    .rd_vld     (bus.cfg_rd_vld),
    .rd_data    (bus.cfg_rd_data),
    .req_rdy    (bus.cfg_req_rdy)
  );

  for (genvar g = 0; g < MAX_DIM; g++) begin : g_dim
    assign dim_base_ptr[32*g +: 32] = dim_q[g];
  end

  assign bus.cfg_wr_ack = ack_q;
  assign bus.cfg_wr_err = wr_err_q;
  assign cfg_done = (lock_q == CFG_LOCKED);
  assign irq      = status_q | (|err_q);

endmodule

// File: tb/tb_svm_cfg_regfile.sv
// Self-checking bench for svm_cfg_regfile: spec-level
// register model plus directed literal expectations.
module tb_svm_cfg_regfile;
  import svm_cfg_pkg::*;

  localparam int MAX_DIM = 4;
  localparam int OW = 2 + 3 + 10*32 + MAX_DIM*32 + 2;
`ifdef SVM_CFG_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk, rst;
  logic batch_comp_done, core_busy;
  logic [1:0]  op_mode;
  logic [2:0]  data_type;
  logic [31:0] auto_split, train_data_base;
  logic [31:0] test_data_base, train_algo, num_dim;
  logic [31:0] num_data_points, mode_dataset_org;
  logic [31:0] infer_res_base_ptr, infer_res_blk_size;
  logic [31:0] scatter_base_ptr;
  logic [MAX_DIM*32-1:0] dim_base_ptr;
  logic cfg_done, irq;

  svm_cfg_regfile_if #(.ADDR_W(16)) bus ();

  svm_cfg_regfile #(.MAX_DIM(MAX_DIM), .ADDR_W(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .batch_comp_done    (batch_comp_done),
    .core_busy          (core_busy),
    .op_mode            (op_mode),
    .data_type          (data_type),
    .auto_split         (auto_split),
    .train_data_base    (train_data_base),
    .test_data_base     (test_data_base),
    .train_algo         (train_algo),
    .num_dim            (num_dim),
    .num_data_points    (num_data_points),
    .mode_dataset_org   (mode_dataset_org),
    .infer_res_base_ptr (infer_res_base_ptr),
    .infer_res_blk_size (infer_res_blk_size),
    .scatter_base_ptr   (scatter_base_ptr),
    .dim_base_ptr       (dim_base_ptr),
    .cfg_done           (cfg_done),
    .irq                (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run = 0;

  task automatic chk(input string n,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  // Register model in terms of the address map.
  logic [31:0] m_reg [64];
  bit          m_locked, m_status;
  logic [2:0]  m_err;
  logic [15:0] m_cap;

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_reg[i] = '0;
    m_reg[0] = 1; m_reg[1] = 2;
    m_reg[2] = 32'h3e4ccccd; m_reg[5] = 1;
    m_reg[6] = 2; m_reg[7] = 1024; m_reg[8] = 2;
    m_reg[12] = 32'h200; m_reg[13] = 1;
    m_locked = 0; m_status = 0;
    m_err = '0; m_cap = '0;
  endfunction

  function automatic void m_raise(input logic [2:0] es,
                                  input int a);
    logic [31:0] av;
    av = a;
    if (es != 0 && m_err == 0)
      m_cap = CAP ? av[15:0] : 16'h0;
    m_err = m_err | es;
  endfunction

  function automatic void m_write(input int a,
                                  input logic [31:0] d);
    if (a == 15 || a >= 16 + MAX_DIM)
      m_raise(3'b010, a);
    else if (a == 9) begin
      if (m_locked && !d[0] && core_busy)
        m_raise(3'b001, a);
      else
        m_locked = d[0];
    end else if (a == 10) begin
      if (d[0]) m_status = 0;
    end else if (a == 11) begin
      m_err = m_err & ~d[2:0];
      if (m_err == 0) m_cap = '0;
    end else if (m_locked)
      m_raise(3'b001, a);
    else if (a == 6) begin
      if (d == 0) begin
        m_reg[6] = 1; m_raise(3'b100, a);
      end else if (d > MAX_DIM) begin
        m_reg[6] = MAX_DIM; m_raise(3'b100, a);
      end else
        m_reg[6] = d;
    end else if (a == 0) m_reg[0] = d & 3;
    else if (a == 1) m_reg[1] = d & 7;
    else m_reg[a] = d;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a <= 8 || (a >= 12 && a <= 14) ||
        (a >= 16 && a < 16 + MAX_DIM))
      return m_reg[a];
    if (a == 9)  return {31'd0, m_locked};
    if (a == 10) return {31'd0, m_status};
    if (a == 11) return {m_cap, 13'd0, m_err};
    m_raise(3'b010, a);
    return '0;
  endfunction

  logic [OW-1:0] g_out, e_out;
  logic [MAX_DIM*32-1:0] e_dim;
  always @(negedge clk) begin
    if (!rst && run) begin
      for (int d = 0; d < MAX_DIM; d++)
        e_dim[32*d +: 32] = m_reg[16+d];
      g_out = {op_mode, data_type, auto_split,
               train_data_base, test_data_base,
               train_algo, num_dim, num_data_points,
               mode_dataset_org, infer_res_base_ptr,
               infer_res_blk_size, scatter_base_ptr,
               dim_base_ptr, cfg_done, irq};
      e_out = {m_reg[0][1:0], m_reg[1][2:0], m_reg[2],
               m_reg[3], m_reg[4], m_reg[5], m_reg[6],
               m_reg[7], m_reg[8], m_reg[12], m_reg[13],
               m_reg[14], e_dim, m_locked,
               m_status | (m_err != 0)};
      chk("outs", 512'(g_out), 512'(e_out));
    end
  end

  task automatic wr(input int a, input logic [31:0] d,
                    input logic exp_err, input bit bcd = 0);
    chk("wr_req_rdy", 512'(bus.cfg_req_rdy), 512'(1));
    bus.cfg_req_vld = 1; bus.cfg_data_rb_w = 1;
    bus.cfg_addr = 16'(a); bus.cfg_data = d;
    batch_comp_done = bcd;
    @(posedge clk);
    m_write(a, d);
    if (bcd) m_status = 1;
    #1;
    bus.cfg_req_vld = 0; batch_comp_done = 0;
    @(negedge clk);
    chk("wr_ack", 512'(bus.cfg_wr_ack), 512'(1));
    chk($sformatf("wr_err@%0d", a),
        512'(bus.cfg_wr_err), 512'(exp_err));
    @(posedge clk); #1;
    chk("wr_ack_drop", 512'(bus.cfg_wr_ack), 512'(0));
  endtask

  task automatic rd(input int a, input int hold,
                    input logic [31:0] exp);
    logic [31:0] m;
    bus.cfg_req_vld = 1; bus.cfg_data_rb_w = 0;
    bus.cfg_addr = 16'(a); bus.cfg_rd_rdy = 0;
    @(posedge clk);
    m = m_read(a);
    #1;
    bus.cfg_req_vld = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_vld", 512'(bus.cfg_rd_vld), 512'(1));
      chk("hold_data", 512'(bus.cfg_rd_data), 512'(m));
      chk("hold_rdy", 512'(bus.cfg_req_rdy), 512'(0));
      @(posedge clk); #1;
    end
    bus.cfg_rd_rdy = 1;
    @(negedge clk);
    chk("rd_vld", 512'(bus.cfg_rd_vld), 512'(1));
    chk($sformatf("rd@%0d", a),
        512'(bus.cfg_rd_data), 512'(exp));
    @(posedge clk); #1;
    bus.cfg_rd_rdy = 0;
    chk("rd_vld_drop", 512'(bus.cfg_rd_vld), 512'(0));
    chk("rd_req_rdy", 512'(bus.cfg_req_rdy), 512'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  logic [31:0] rst_tbl [15];
  initial begin
    rst_tbl = '{32'd1, 32'd2, 32'h3e4ccccd, 32'd0,
                32'd0, 32'd1, 32'd2, 32'd1024, 32'd2,
                32'd0, 32'd0, 32'd0, 32'h200, 32'd1,
                32'd0};
    rst = 1; batch_comp_done = 0; core_busy = 0;
    bus.cfg_req_vld = 0; bus.cfg_data_rb_w = 0;
    bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.cfg_rd_rdy = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_rd_vld", 512'(bus.cfg_rd_vld), 512'(0));
    chk("rst_rd_data", 512'(bus.cfg_rd_data), 512'(0));
    chk("rst_wr_ack", 512'(bus.cfg_wr_ack), 512'(0));
    chk("rst_wr_err", 512'(bus.cfg_wr_err), 512'(0));
    chk("rst_req_rdy", 512'(bus.cfg_req_rdy), 512'(1));
    chk("rst_irq", 512'(irq), 512'(0));
    run = 1;

    for (int a = 0; a < 15; a++)
      rd(a, 0, rst_tbl[a]);

    wr(6, 9, 0);
    rd(6, 0, 32'd4);
    chk("irq_nd", 512'(irq), 512'(1));
    rd(11, 0, CAP ? 32'h0006_0004 : 32'h4);
    wr(11, 32'h4, 0);
    rd(11, 0, 32'h0);
    chk("irq_clr", 512'(irq), 512'(0));
    wr(6, 0, 0);
    rd(6, 0, 32'd1);
    wr(11, 32'h4, 0);
    wr(6, 3, 0);
    wr(0, 32'hff, 0);
    rd(0, 0, 32'd3);
    wr(1, 32'hff, 0);
    rd(1, 0, 32'd7);
    wr(17, 32'habc, 0);
    rd(17, 0, 32'habc);

    wr(9, 1, 0);
    chk("locked", 512'(cfg_done), 512'(1));
    wr(3, 32'h1000, 1);
    rd(3, 0, 32'h0);
    rd(11, 0, CAP ? 32'h0003_0001 : 32'h1);
    wr(17, 32'h55, 1);
    core_busy = 1;
    wr(9, 0, 1);
    chk("still_locked", 512'(cfg_done), 512'(1));
    wr(10, 1, 0);
    core_busy = 0;
    wr(11, 32'hffff_ffff, 0);
    wr(9, 0, 0);
    chk("unlocked", 512'(cfg_done), 512'(0));

    rd(12, 5, 32'h200);

    @(posedge clk);
    m_status = 1;
    batch_comp_done = 1;
    #1 batch_comp_done = 0;
    @(posedge clk); #1;
    wr(10, 1, 0, 1);
    rd(10, 0, 32'd1);
    wr(10, 1, 0);
    rd(10, 0, 32'd0);

    rd(20, 0, 32'h0);
    rd(11, 0, CAP ? 32'h0014_0002 : 32'h2);
    wr(15, 32'h1, 1);
    wr(11, 32'h7, 0);

    bus.cfg_req_vld = 1; bus.cfg_data_rb_w = 1;
    bus.cfg_addr = 16'd3; bus.cfg_data = 32'h11;
    @(posedge clk);
    m_write(3, 32'h11);
    #1 bus.cfg_addr = 16'd4; bus.cfg_data = 32'h22;
    @(negedge clk);
    chk("b2b_ack0", 512'(bus.cfg_wr_ack), 512'(1));
    @(posedge clk);
    m_write(4, 32'h22);
    #1 bus.cfg_req_vld = 0;
    @(negedge clk);
    chk("b2b_ack1", 512'(bus.cfg_wr_ack), 512'(1));
    chk("b2b_err1", 512'(bus.cfg_wr_err), 512'(0));
    @(posedge clk); #1;
    rd(4, 0, 32'h22);

    bus.cfg_req_vld = 1; bus.cfg_data_rb_w = 0;
    bus.cfg_addr = 16'd3;
    @(posedge clk);
    #1 bus.cfg_req_vld = 0;
    chk("mid_vld", 512'(bus.cfg_rd_vld), 512'(1));
    #2 rst = 1;
    m_reset();
    #1;
    chk("mid_rst_vld", 512'(bus.cfg_rd_vld), 512'(0));
    chk("mid_rst_op", 512'(train_data_base), 512'(0));
    @(posedge clk); #1 rst = 0;
    rd(3, 0, 32'h0);
    rd(2, 0, 32'h3e4ccccd);

    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
